hex_uart_reporter: RTL and testbench
====================================

// Module: hex_uart_reporter
// PURPOSE
//   Downstream consumer of the 24-bit free-running counter in the top-level test design.
//   On a sample strobe it snapshots the counter value and transmits it over a UART TX pin.
//   Frame format: 6 uppercase ASCII hex digits, then CR LF. Serial format is 8N1, LSB first.
//   Lets the board-level counter test be checked from a host terminal, not only on io_out pins.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per UART bit; legal range >= 2 (e.g. 12 MHz / 115200 -> 104)
//   VALUE_W       24  width of value input; fixed at 24 = 6 hex digits, other values illegal
// PORTS
//   clk          in   1   single system clock; all logic on posedge
//   rst          in   1   reset; synchronous, active-high
//   value        in   24  counter value to report; sampled only on an accepted strobe
//   sample       in   1   one-cycle request to report the current value
//   tx           out  1   UART serial output, idle high
//   busy         out  1   high while a frame is in flight
//   dropped_cnt  out  8   saturating count of strobes rejected while busy
// BEHAVIOUR
//   Reset
//     - Sync active-high; next edge: tx=1, busy=0, dropped_cnt=0, FSM=IDLE.
//     - Timers, char index, bit index and shift register are all cleared.
//     - rst mid-frame aborts the frame: tx returns high the cycle after rst is sampled.
//       No partial character is completed.
//   Accept
//     - Strobe accepted when sample=1 AND state==IDLE.
//     - On accept: value latched into snap[23:0]; busy=1 and tx=0 (start bit) from the next cycle.
//     - Latency from accept to the tx falling edge is exactly 1 cycle.
//   Reject
//     - sample=1 while busy is ignored; snap and tx are unaffected.
//     - dropped_cnt += 1, saturating at 255 (no wrap).
//   Character sequence (char index 0..7)
//     - Index 0..5 = snap[23:20] .. snap[3:0].
//     - Each nibble n maps to n<10 ? 0x30+n : 0x37+n (i.e. '0'-'9', 'A'-'F').
//     - Index 6 = 0x0D, index 7 = 0x0A.
//   FSM: IDLE -> START -> DATA -> STOP -> (START | IDLE)
//     - START: tx=0 for CLKS_PER_BIT cycles.
//     - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit index 0..7.
//     - STOP: tx=1 for CLKS_PER_BIT cycles.
//     - At end of STOP: if char index < 7, increment it and go to START.
//       Otherwise go to IDLE.
//     - No idle gap between characters in a frame.
//   Timing
//     - Bit timer counts 0..CLKS_PER_BIT-1 and wraps; the bit boundary is at the wrap.
//     - Timer reloads on every state change.
//     - Frame length: 80*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
//   Frame end and back-to-back
//     - busy drops in the cycle after the last stop-bit cycle (state IDLE).
//     - A strobe in that same cycle is accepted, so minimum inter-frame idle = 1 cycle of tx=1.
//   value changes after accept never affect the frame in flight.
//   Simultaneous rst and sample: rst wins; nothing is latched and dropped_cnt is not incremented.
//   tx is registered (no combinational path from any input to tx).
// TESTING (CLKS_PER_BIT=4 unless noted; bench UART decoder samples at mid-bit)
//   1. Reset, then idle 50 cycles -> tx=1, busy=0, dropped_cnt=0 throughout.
//   2. value=24'h1234AB, 1-cycle sample -> tx low exactly 1 cycle later.
//      Decoder reads "1234AB",0x0D,0x0A. busy high for 320 cycles.
//   3. value=24'h000000, then 24'hFFFFFF -> "000000\r\n" and "FFFFFF\r\n".
//      Checks the 9/A boundary; value=24'h9A9A9A -> "9A9A9A\r\n".
//   4. Strobe at the first cycle busy=0 after frame 1 -> second frame starts after exactly 1 idle-high cycle.
//      Changing value mid-frame does not alter the output.
//   5. 300 strobes while busy -> dropped_cnt=255 (saturated); the frame in flight is unchanged.
//   6. rst asserted during DATA of char 3 -> tx=1, busy=0 next cycle.
//      A fresh strobe afterwards sends a complete, correct frame.

Source files
------------

// File: rtl/hex_uart_reporter.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// hex_uart_reporter : snapshots a 24-bit value on a strobe and sends it over
//                     8N1 UART as six uppercase hex digits followed by CR LF.
// Revision 1.0
// ----------------------------------------------------------------------------
module hex_uart_reporter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int VALUE_W      = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               sample,
  output logic               tx,
  output logic               busy,
  output logic [7:0]         dropped_cnt
);

  localparam int c_tw = $clog2(CLKS_PER_BIT);
  localparam logic [c_tw-1:0] c_last_tick = c_tw'(CLKS_PER_BIT - 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_start = 2'd1;
  localparam logic [1:0] c_st_data  = 2'd2;
  localparam logic [1:0] c_st_stop  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [c_tw-1:0]    timer_q, timer_d;
  logic [2:0]         char_idx_q, char_idx_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [VALUE_W-1:0] snap_q, snap_d;
  logic [7:0]         dropped_q, dropped_d;
  logic               tx_q, tx_d;
  logic               tick_end;
  logic [7:0]         char_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign tick_end = (timer_q == c_last_tick);

  always_comb begin
    char_byte = 8'h0A;
    case (char_idx_q)
      3'd0:    char_byte = hex_ascii(snap_q[23:20]);
      3'd1:    char_byte = hex_ascii(snap_q[19:16]);
      3'd2:    char_byte = hex_ascii(snap_q[15:12]);
      3'd3:    char_byte = hex_ascii(snap_q[11:8]);
      3'd4:    char_byte = hex_ascii(snap_q[7:4]);
      3'd5:    char_byte = hex_ascii(snap_q[3:0]);
      3'd6:    char_byte = 8'h0D;
      default: char_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_st_idle;
      timer_q    <= '0;
      char_idx_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      snap_q     <= '0;
      dropped_q  <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      char_idx_q <= char_idx_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      snap_q     <= snap_d;
      dropped_q  <= dropped_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:  if (sample) state_d = c_st_start;
      c_st_start: if (tick_end) state_d = c_st_data;
      c_st_data:  if (tick_end && bit_idx_q == 3'd7) state_d = c_st_stop;
      c_st_stop:  if (tick_end) state_d = (char_idx_q == 3'd7) ? c_st_idle : c_st_start;
      default:    state_d = c_st_idle;
    endcase
  end

  // The byte is loaded at the start->data boundary so tx can be computed from next-state values.
  always_comb begin
    timer_d    = timer_q;
    char_idx_d = char_idx_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    snap_d     = snap_q;
    dropped_d  = dropped_q;
    tx_d       = 1'b1;

    if (state_q == c_st_idle || state_d != state_q || tick_end) timer_d = '0;
    else                                                        timer_d = timer_q + c_tw'(1);

    if (sample && state_q != c_st_idle && dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;

    case (state_q)
      c_st_idle: if (sample) begin
        snap_d     = value;
        char_idx_d = 3'd0;
      end
      c_st_start: if (tick_end) begin
        shift_d   = char_byte;
        bit_idx_d = 3'd0;
      end
      c_st_data: if (tick_end) begin
        shift_d   = {1'b0, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
      end
      c_st_stop: if (tick_end && char_idx_q != 3'd7) char_idx_d = char_idx_q + 3'd1;
      default: ;
    endcase

    case (state_d)
      c_st_start: tx_d = 1'b0;
      c_st_data:  tx_d = shift_d[0];
      default:    tx_d = 1'b1;
    endcase
  end

  assign tx          = tx_q;
  assign busy        = (state_q != c_st_idle);
  assign dropped_cnt = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_uart_reporter.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hex_uart_reporter : directed bench decoding frames at mid-bit.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_hex_uart_reporter;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample = 1'b0;
  logic [23:0] value = 24'h0;
  logic        tx;
  logic        busy;
  logic [7:0]  dropped_cnt;

  int checks = 0;
  int errors = 0;

  hex_uart_reporter #(.CLKS_PER_BIT(CPB), .VALUE_W(24)) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .sample      (sample),
    .tx          (tx),
    .busy        (busy),
    .dropped_cnt (dropped_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(input logic [23:0] v, input int k);
    string hx;
    hx = "0123456789ABCDEF";
    if (k == 6) return 8'h0D;
    if (k == 7) return 8'h0A;
    return hx[int'(v[23-4*k -: 4])];
  endfunction

  task automatic start_frame(input logic [23:0] v, input string tag);
    chk({tag, "_pre_idle"}, {31'd0, tx}, 32'd1);
    value  = v;
    sample = 1'b1;
    tick();
    sample = 1'b0;
    chk({tag, "_latency"}, {30'd0, busy, tx}, 32'd2);
  endtask

  // Called at the first start-bit cycle; returns at the first cycle after the frame.
  task automatic recv_frame(input logic [23:0] v, input string tag, input bit chg, input bit spam);
    logic [7:0] rx [8];
    int ferr;
    int bp;
    bit busy_ok;
    ferr    = 0;
    busy_ok = 1'b1;
    for (int k = 0; k < 8; k++) rx[k] = 8'h00;
    for (int off = 0; off < 80*CPB; off++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (off % CPB == CPB/2) begin
        bp = off / CPB;
        if (bp % 10 == 0) begin
          if (tx !== 1'b0) ferr++;
        end else if (bp % 10 == 9) begin
          if (tx !== 1'b1) ferr++;
        end else begin
          rx[bp/10][bp%10 - 1] = tx;
        end
      end
      if (chg && off == 50) value = 24'h5A5A5A;
      if (spam) sample = (off < 300);
      tick();
    end
    sample = 1'b0;
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_char%0d", tag, k), {24'd0, rx[k]}, {24'd0, exp_char(v, k)});
    chk({tag, "_framing"}, ferr, 32'd0);
    chk({tag, "_busy_hold"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_end"}, {30'd0, busy, tx}, 32'd1);
  endtask

  initial begin
    bit idle_ok;

    rst = 1'b1;
    tick();
    tick();
    chk("reset_state", {22'd0, tx, busy, dropped_cnt}, {22'd0, 1'b1, 1'b0, 8'd0});
    rst = 1'b0;

    idle_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || dropped_cnt !== 8'd0) idle_ok = 1'b0;
    end
    chk("idle_50", {31'd0, idle_ok}, 32'd1);

    rst    = 1'b1;
    sample = 1'b1;
    value  = 24'hFFFFFF;
    tick();
    rst    = 1'b0;
    sample = 1'b0;
    chk("rst_sample_same_cycle", {22'd0, tx, busy, dropped_cnt}, {22'd0, 1'b1, 1'b0, 8'd0});
    tick();
    chk("rst_sample_still_idle", {30'd0, tx, busy}, 32'd2);

    start_frame(24'h1234AB, "f1");
    recv_frame(24'h1234AB, "f1", 1'b1, 1'b0);
    chk("f1_no_drops", {24'd0, dropped_cnt}, 32'd0);

    start_frame(24'h000000, "f2");
    recv_frame(24'h000000, "f2", 1'b0, 1'b0);
    start_frame(24'hFFFFFF, "f3");
    recv_frame(24'hFFFFFF, "f3", 1'b0, 1'b0);
    start_frame(24'h9A9A9A, "f4");
    recv_frame(24'h9A9A9A, "f4", 1'b0, 1'b1);
    chk("dropped_saturated", {24'd0, dropped_cnt}, 32'd255);

    tick();
    tick();
    start_frame(24'hABCDEF, "f5");
    repeat (130) tick();
    chk("f5_mid_busy", {31'd0, busy}, 32'd1);
    rst    = 1'b1;
    sample = 1'b1;
    tick();
    rst    = 1'b0;
    sample = 1'b0;
    chk("abort_state", {22'd0, tx, busy, dropped_cnt}, {22'd0, 1'b1, 1'b0, 8'd0});
    tick();
    chk("abort_stays_idle", {30'd0, tx, busy}, 32'd2);

    start_frame(24'hFEDCBA, "f6");
    recv_frame(24'hFEDCBA, "f6", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
